alu_result_stage: RTL
=====================

Name: alu_result_stage

Overview:
Registered output stage directly downstream of the combinational ALU. It captures result and carry from the ALU together with the issuing opcode and a tag, and computes a zero flag. Entries are buffered in a 2-entry skid FIFO and presented to the writeback consumer over a valid/ready handshake. It also keeps a sticky carry flag and a wrapping retire counter for debug and status.

Parameters:
WIDTH, 64, datapath width; must match the ALU result width.
TAG_W, 4, width of the opaque transaction tag carried alongside each result.
CNT_W, 32, width of the retired-result counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  ALU output holds a result to capture this cycle.
in_ready  output  1  stage can accept a result this cycle.
in_opcode  input  4  opcode that produced the result (0 ADD, 1 SUB, 2 AND, 3 OR, 4 MIN).
in_result  input  WIDTH  ALU result.
in_carry  input  1  ALU carryFlag.
in_tag  input  TAG_W  tag issued with the operation.
out_valid  output  1  head entry is valid.
out_ready  input  1  consumer accepts the head entry.
out_result  output  WIDTH  head result.
out_carry  output  1  head carry, qualified by opcode.
out_zero  output  1  head result equals zero.
out_opcode  output  4  head opcode.
out_tag  output  TAG_W  head tag.
sticky_carry  output  1  set on retire of any entry with out_carry=1.
sticky_clr  input  1  clears sticky_carry.
retire_count  output  CNT_W  number of handshakes completed on the output side.

Behaviour:
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- in_ready = (occupancy < 2). It is driven from registered occupancy only and has no combinational path from out_ready.
- Storage: 2 entries, each holding {result, carry_q, zero, opcode, tag}. Read and write pointers are 1 bit wide and wrap. Occupancy range is 0..2.
- Capture rules:
  - carry_q = in_carry only when in_opcode is 0 or 1; otherwise carry_q = 0.
  - zero = (in_result == 0), computed at capture.
  - Opcodes 5..15 are captured unchanged, with carry_q = 0.
- Latency: an entry pushed in cycle N appears on out_* in cycle N+1 at the earliest. There is no combinational pass-through.
- out_* reflect the head entry whenever out_valid=1. The head is stable while out_valid && !out_ready. When out_valid=0 the out_* values are don't-care; the implementation drives zeros.
- Simultaneous push and pop:
  - Occupancy 1: occupancy stays 1 and the new entry becomes head next cycle.
  - Occupancy 2: push is impossible because in_ready=0.
  - Occupancy 0: push only.
- Full: in_ready=0; in_valid is ignored and the ALU side must hold.
- Empty: out_valid=0; out_ready is ignored.
- retire_count increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- sticky_carry:
  - Set when a pop occurs with head carry=1.
  - Cleared by sticky_clr.
  - If both happen in the same cycle, set wins and sticky_carry=1.
- Reset (asynchronous, any time, including mid-handshake): occupancy=0, pointers=0, out_valid=0, in_ready=1 immediately, out_result/out_carry/out_zero/out_opcode/out_tag=0, sticky_carry=0, retire_count=0. Buffered entries are discarded. After deassertion the first push may occur on the first rising edge.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_MIN=4;
  - the 4-bit opcode width constant;
  - a function is_arith(op) returning 1 for ADD/SUB.
- One natural sub-module: alu_skid_fifo2, a generic 2-entry valid/ready buffer parameterised on payload width. The top packs and unpacks the payload and owns the flags and counter.

Test Plan:
1. ADD result 64'h0, carry 1, tag 3, out_ready=1 -> next cycle out_valid=1, out_result=0, out_zero=1, out_carry=1, out_tag=3; retire_count 0->1; sticky_carry=1.
2. AND result 64'hFF with in_carry=1 -> out_carry=0, out_zero=0, sticky_carry unchanged.
3. out_ready=0, push tags 1 then 2 -> in_ready=0 after the second push; a third in_valid is not captured. Raise out_ready -> tags emerge 1 then 2 in order with results intact; in_ready=1 after the first pop.
4. Occupancy 1, simultaneous push (tag 5) and pop (tag 4) -> occupancy stays 1, tag 5 at head next cycle, retire_count +1.
5. sticky_clr asserted in the same cycle as a pop of a SUB with carry=1 -> sticky_carry=1. sticky_clr alone on the next cycle -> sticky_carry=0.
6. Assert rst_n=0 mid-cycle with 2 entries held and out_valid=1 -> out_valid=0 and in_ready=1 without a clock edge, retire_count=0, all outputs zero. After release, a single push -> out_valid the next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU and its result stage:
//   OPCODE_W          width of the opcode field carried with every result
//   OP_ADD .. OP_MIN  opcode encodings produced by the issue logic
//   is_arith(op)      1 when the opcode produces a meaningful carry (ADD/SUB)
package alu_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_ADD = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_AND = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_OR  = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_MIN = 4'd4;

  // Only add and subtract leave a carry worth reporting; every other
  // opcode (including unassigned ones) has its carry forced low.
  function automatic logic is_arith(input logic [OPCODE_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_skid_fifo2.sv
// alu_skid_fifo2
// Generic 2-entry valid/ready buffer with an opaque payload.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake; in_ready depends only on
//                         registered occupancy
//   in_data               payload written on a push
//   out_valid / out_ready downstream handshake
//   out_data              head payload, zeros while empty
// Every entry passes through a register, so there is no same-cycle
// path from input to output.
module alu_skid_fifo2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              push, pop;

  // Handshake flags come straight from the occupancy register.
  always_comb begin
    in_ready  = (count_q != 2'd2);
    out_valid = (count_q != 2'd0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  end

  // Next-state for storage, the wrapping 1-bit pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage
// Registered output stage behind the combinational ALU. Each accepted
// result is captured with its opcode, tag, an opcode-qualified carry and a
// zero flag, buffered in a 2-entry skid FIFO and handed to writeback.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               ALU-side handshake
//   in_opcode/in_result/in_carry/in_tag   ALU outputs for this cycle
//   out_valid/out_ready             writeback-side handshake
//   out_result/out_carry/out_zero/out_opcode/out_tag   head entry
//   sticky_carry/sticky_clr         carry seen on any retired entry
//   retire_count                    wrapping count of output handshakes
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] in_opcode,
  input  logic [WIDTH-1:0]    in_result,
  input  logic                in_carry,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_result,
  output logic                out_carry,
  output logic                out_zero,
  output logic [OPCODE_W-1:0] out_opcode,
  output logic [TAG_W-1:0]    out_tag,
  output logic                sticky_carry,
  input  logic                sticky_clr,
  output logic [CNT_W-1:0]    retire_count
);

  localparam int PAYLOAD_W = WIDTH + 2 + OPCODE_W + TAG_W;

  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] head_payload;
  logic                 cap_carry;
  logic                 cap_zero;
  logic                 pop;
  logic                 sticky_q, sticky_d;
  logic [CNT_W-1:0]     retire_q, retire_d;

  // Capture-time flags: carry only survives for ADD/SUB, zero is
  // evaluated here so the consumer never sees a wide compare.
  always_comb begin
    cap_carry  = is_arith(in_opcode) ? in_carry : 1'b0;
    cap_zero   = (in_result == '0);
    in_payload = {in_result, cap_carry, cap_zero, in_opcode, in_tag};
  end

  alu_skid_fifo2 #(
    .DATA_W (PAYLOAD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_payload)
  );

  // The FIFO returns zeros while empty, so the unpacked fields do too.
  assign {out_result, out_carry, out_zero, out_opcode, out_tag} = head_payload;

  // Retiring a carry takes priority over a clear in the same cycle.
  always_comb begin
    pop      = out_valid && out_ready;
    sticky_d = sticky_q;
    retire_d = retire_q;
    if (pop && out_carry) begin
      sticky_d = 1'b1;
    end else if (sticky_clr) begin
      sticky_d = 1'b0;
    end
    if (pop) begin
      retire_d = retire_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      retire_q <= '0;
    end else begin
      sticky_q <= sticky_d;
      retire_q <= retire_d;
    end
  end

  assign sticky_carry = sticky_q;
  assign retire_count = retire_q;

endmodule
